// File: rtl/fault_mem_cfg_if.sv
// Access and fault-configuration bus of the fault-injecting SRAM model.
// The master side is the MBIST controller or bench; the slave side is the memory.
interface fault_mem_cfg_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  write_read;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  cfg_en;
   logic [3:0]            cfg_idx;
   logic [2:0]            cfg_type;
   logic [ADDR_WIDTH-1:0] cfg_addr;
   logic [ADDR_WIDTH-1:0] cfg_aux;
   logic [4:0]            cfg_bit;
   logic                  fault_hit;

   modport master (
      output write_read, address, wdata,
      output cfg_en, cfg_idx, cfg_type, cfg_addr, cfg_aux, cfg_bit,
      input  rdata, rvalid, fault_hit
   );

   modport slave (
      input  write_read, address, wdata,
      input  cfg_en, cfg_idx, cfg_type, cfg_addr, cfg_aux, cfg_bit,
      output rdata, rvalid, fault_hit
   );
endinterface

// File: rtl/fault_mem_cfg.sv
// Behavioural single-port SRAM with a run-time programmable fault table.
// Write data is registered one cycle ahead of its write; reads take two edges.
module fault_mem_cfg #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 16,
   parameter int          DEPTH      = 65536,
   parameter int          NUM_FAULTS = 4,
   parameter logic [31:0] CONST_PAT  = 32'hAB
) (
   input logic             clk,
   input logic             rst_n,
   fault_mem_cfg_if.slave  bus
);

   typedef enum logic [2:0] {
      FT_NONE     = 3'd0,
      FT_SA0      = 3'd1,
      FT_SA1      = 3'd2,
      FT_TF_UP    = 3'd3,
      FT_TF_DN    = 3'd4,
      FT_CF_INV   = 3'd5,
      FT_AF_ALIAS = 3'd6,
      FT_RD_CONST = 3'd7
   } fault_t;

   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_PAT);
   localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   fault_t                ent_type_q [NUM_FAULTS];
   logic [ADDR_WIDTH-1:0] ent_addr_q [NUM_FAULTS];
   logic [ADDR_WIDTH-1:0] ent_aux_q  [NUM_FAULTS];
   logic [DATA_WIDTH-1:0] ent_mask_q [NUM_FAULTS];

   logic [DATA_WIDTH-1:0] wd_q;
   logic [DATA_WIDTH-1:0] stage1_q, stage1_d;
   logic                  s1_vld_q, s1_vld_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;
   logic                  hit_q, hit_d;

   logic                  in_rng;
   logic                  rd_const;
   logic                  alias_fnd;
   logic [ADDR_WIDTH-1:0] phys;
   logic                  phys_ok;
   logic                  wr_store;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [NUM_FAULTS-1:0] cf_fire;
   logic [DATA_WIDTH-1:0] cf_mask [NUM_FAULTS];

   // Fault table; the bit index is stored pre-decoded as a one-hot mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FAULTS; i++) begin
            ent_type_q[i] <= FT_NONE;
            ent_addr_q[i] <= '0;
            ent_aux_q[i]  <= '0;
            ent_mask_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FAULTS; i++) begin
            if (bus.cfg_en && (int'(bus.cfg_idx) == i)) begin
               ent_type_q[i] <= fault_t'(bus.cfg_type);
               ent_addr_q[i] <= bus.cfg_addr;
               ent_aux_q[i]  <= bus.cfg_aux;
               ent_mask_q[i] <= ONE << (32'(bus.cfg_bit) % 32'(DATA_WIDTH));
            end
         end
      end
   end

   always_comb begin
      in_rng    = ({1'b0, bus.address} < DEPTH_L);
      rd_const  = 1'b0;
      alias_fnd = 1'b0;
      phys      = bus.address;
      hit_d     = 1'b0;
      for (int i = 0; i < NUM_FAULTS; i++) begin
         if (in_rng && (ent_type_q[i] != FT_NONE) && (ent_addr_q[i] == bus.address))
            hit_d = 1'b1;
         if (in_rng && (ent_type_q[i] == FT_CF_INV) && (ent_aux_q[i] == bus.address))
            hit_d = 1'b1;
         if (in_rng && (ent_type_q[i] == FT_RD_CONST) && (ent_addr_q[i] == bus.address))
            rd_const = 1'b1;
         if (in_rng && !alias_fnd && (ent_type_q[i] == FT_AF_ALIAS) &&
             (ent_addr_q[i] == bus.address)) begin
            alias_fnd = 1'b1;
            phys      = ent_aux_q[i];
         end
      end

      phys_ok  = in_rng && !rd_const && ({1'b0, phys} < DEPTH_L);
      old_word = phys_ok ? mem[phys] : '0;
      wr_word  = wd_q;
      rd_word  = old_word;

      // Bit faults act on the resolved word in ascending index order.
      for (int i = 0; i < NUM_FAULTS; i++) begin
         if (ent_addr_q[i] == phys) begin
            case (ent_type_q[i])
               FT_SA0: begin
                  wr_word = wr_word & ~ent_mask_q[i];
                  rd_word = rd_word & ~ent_mask_q[i];
               end
               FT_SA1: begin
                  wr_word = wr_word | ent_mask_q[i];
                  rd_word = rd_word | ent_mask_q[i];
               end
               FT_TF_UP: begin
                  if (((old_word & ent_mask_q[i]) == '0) && ((wr_word & ent_mask_q[i]) != '0))
                     wr_word = wr_word & ~ent_mask_q[i];
               end
               FT_TF_DN: begin
                  if (((old_word & ent_mask_q[i]) != '0) && ((wr_word & ent_mask_q[i]) == '0))
                     wr_word = wr_word | ent_mask_q[i];
               end
               default: ;
            endcase
         end
      end
      if (rd_const)
         rd_word = CONST_W;

      wr_store = rst_n && bus.write_read && phys_ok;

      for (int i = 0; i < NUM_FAULTS; i++) begin
         cf_fire[i] = wr_store && (ent_type_q[i] == FT_CF_INV) &&
                      (ent_aux_q[i] == phys) && (ent_aux_q[i] != ent_addr_q[i]) &&
                      ({1'b0, ent_addr_q[i]} < DEPTH_L);
      end
      // Coupling entries sharing one victim fold into a single XOR mask.
      for (int i = 0; i < NUM_FAULTS; i++) begin
         cf_mask[i] = '0;
         for (int j = 0; j < NUM_FAULTS; j++) begin
            if (cf_fire[j] && (ent_addr_q[j] == ent_addr_q[i]))
               cf_mask[i] = cf_mask[i] ^ ent_mask_q[j];
         end
      end

      stage1_d = rd_word;
      s1_vld_d = !bus.write_read;
   end

   // Array has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_store)
         mem[phys] <= wr_word;
      for (int i = 0; i < NUM_FAULTS; i++) begin
         if (cf_fire[i])
            mem[ent_addr_q[i]] <= mem[ent_addr_q[i]] ^ cf_mask[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q     <= '0;
         stage1_q <= '0;
         s1_vld_q <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         wd_q     <= bus.wdata;
         stage1_q <= stage1_d;
         s1_vld_q <= s1_vld_d;
         if (s1_vld_q)
            rdata_q <= stage1_q;
         rvalid_q <= s1_vld_q;
         hit_q    <= hit_d;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.fault_hit = hit_q;

endmodule
